// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   BYTE_W      : width of one transmitted byte
//   NUM_REQ_DEF / TIMEOUT_DEF : default configuration
//   rr_next()   : round-robin successor with an explicit wrap
package uart_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Explicit compare so non-power-of-two requester counts wrap correctly.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority
//   mask_i  : eligibility mask (bit i = requester i may win)
//   gnt_o   : one-hot winner
//   idx_o   : winner index
//   found_o : a winner exists
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  input  logic [NumReq-1:0] mask_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  always_comb begin
    int unsigned pos;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    // Scan from the pointer upward, wrapping at NumReq.
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NumReq) begin
        pos = pos - NumReq;
      end
      if (!found && req_i[pos] && mask_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IdxW'(pos);
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ clients.
// A byte is captured in IDLE, offered on tx_valid/tx_data in XFER until tx_ready, and
// dropped with a one-cycle timeout_err pulse if not taken within TIMEOUT cycles.
// Optional packet lock: define UART_TX_ARB_LOCK_EN to keep the grant on one requester
// until it sends a byte with req_last set.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   req_valid/data/last    : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready              : one-hot capture strobe (combinational)
//   tx_valid/tx_data       : byte offered to the transmitter
//   tx_ready               : transmitter accepts this cycle
//   grant_id               : current/last granted requester
//   busy                   : high in XFER
//   timeout_err            : one-cycle pulse when a byte is dropped
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  arb_state_t        state_d, state_q;
  logic [BYTE_W-1:0] data_d, data_q;
  logic [IdxW-1:0]   grant_d, grant_q;
  logic [IdxW-1:0]   ptr_d, ptr_q;
  logic [WdW-1:0]    wd_cnt_d, wd_cnt_q;
  logic              timeout_d, timeout_q;
  logic [IdxW-1:0]   next_ptr;

  logic [NUM_REQ-1:0] elig_mask;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_found;

`ifdef UART_TX_ARB_LOCK_EN
  logic locked_d, locked_q;
  // Whether the byte in flight closes its packet; the pointer only moves then.
  logic last_d, last_q;

  assign elig_mask = locked_q ? (NUM_REQ'(1) << grant_q) : '1;
`else
  logic unused_req_last;

  assign unused_req_last = ^req_last;
  assign elig_mask       = '1;
`endif

  rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .mask_i  (elig_mask),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign next_ptr = IdxW'(rr_next(32'(grant_q), NUM_REQ));

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    locked_d  = locked_q;
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          data_d   = req_data[pick_idx*BYTE_W +: BYTE_W];
          grant_d  = pick_idx;
          wd_cnt_d = '0;
          state_d  = XFER;
`ifdef UART_TX_ARB_LOCK_EN
          locked_d = !req_last[pick_idx];
          last_d   = req_last[pick_idx];
`endif
        end
      end
      XFER: begin
        // tx_ready wins over an expiring watchdog.
        if (tx_ready || (wd_cnt_q == WdLast)) begin
          state_d   = IDLE;
          timeout_d = !tx_ready;
`ifdef UART_TX_ARB_LOCK_EN
          if (last_q || !tx_ready) begin
            ptr_d    = next_ptr;
            locked_d = 1'b0;
          end
`else
          ptr_d     = next_ptr;
`endif
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked_q  <= 1'b0;
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
`ifdef UART_TX_ARB_LOCK_EN
      locked_q  <= locked_d;
      last_q    <= last_d;
`endif
    end
  end

  // Gated by reset_n so nothing is captured-looking while reset is held.
  assign req_ready   = ((state_q == IDLE) && reset_n) ? pick_gnt : '0;
  assign tx_valid    = (state_q == XFER);
  assign busy        = (state_q == XFER);
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned NReq = 4;

  logic            clk;
  logic            reset_n;
  logic [NReq-1:0] req_valid;
  logic [NReq*8-1:0] req_data;
  logic [NReq-1:0] req_last;
  logic [NReq-1:0] req_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int n_checks = 0;
  int n_bad    = 0;

  uart_tx_arbiter #(
    .NUM_REQ (NReq),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Return 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int idx;
  int n0;
  int exp_g[4];
  logic [7:0] exp_d[4];

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'hf;
    req_data  = 32'h44332211;
    req_last  = 4'hf;
    tx_ready  = 1'b0;
    step();
    step();
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_tx_valid", 32'(tx_valid), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_grant_id", 32'(grant_id), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_timeout", 32'(timeout_err), 0);

    reset_n = 1'b1;
    #1;
    check_eq("rel_req_ready", 32'(req_ready), 32'h1);
    step();
    check_eq("rel_tx_valid", 32'(tx_valid), 1);
    check_eq("rel_tx_data", 32'(tx_data), 32'h11);
    check_eq("rel_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    step();
    check_eq("rel_idle", 32'(busy), 0);

    // Fairness: all valid, tx_ready held high -> 1,2,3,0,1,... every 2 cycles.
    for (int k = 1; k <= 8; k++) begin
      idx = k % 4;
      #1;
      check_eq("fair_req_ready", 32'(req_ready), 32'(1) << idx);
      step();
      check_eq("fair_grant", 32'(grant_id), 32'(idx));
      check_eq("fair_tx_data", 32'(tx_data), 32'(8'h11 * (idx + 1)));
      check_eq("fair_tx_valid", 32'(tx_valid), 1);
      check_eq("fair_timeout", 32'(timeout_err), 0);
      step();
      check_eq("fair_no_ready_in_idle_edge", 32'(timeout_err), 0);
    end

    // No requests: stay idle.
    req_valid = 4'h0;
    tx_ready  = 1'b0;
    #1;
    check_eq("none_req_ready", 32'(req_ready), 0);
    step();
    check_eq("none_busy", 32'(busy), 0);

    // Pointer skip: ptr=1, only req 2 valid.
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5a;
    #1;
    check_eq("skip_req_ready", 32'(req_ready), 32'h4);
    step();
    check_eq("skip_tx_data", 32'(tx_data), 32'h5a);
    check_eq("skip_grant", 32'(grant_id), 2);
    req_valid = 4'b0010;
    tx_ready  = 1'b1;
    #1;
    check_eq("skip_ready_in_xfer", 32'(req_ready), 0);
    step();
    // ptr=3 now; req 1 is found after wrapping.
    check_eq("skip_wrap_ready", 32'(req_ready), 32'h2);
    step();
    check_eq("skip_wrap_grant", 32'(grant_id), 1);
    check_eq("skip_wrap_data", 32'(tx_data), 32'h22);
    tx_ready  = 1'b0;
    req_valid = 4'hf;

    // Watchdog: TIMEOUT=4 -> 4 cycles of tx_valid, then a single error pulse.
    for (int i = 0; i < 4; i++) begin
      check_eq("wd_tx_valid", 32'(tx_valid), 1);
      check_eq("wd_no_err", 32'(timeout_err), 0);
      step();
    end
    check_eq("wd_err_pulse", 32'(timeout_err), 1);
    check_eq("wd_idle", 32'(tx_valid), 0);
    check_eq("wd_next_ready", 32'(req_ready), 32'h4);
    step();
    check_eq("wd_err_once", 32'(timeout_err), 0);
    check_eq("wd_next_grant", 32'(grant_id), 2);

    // Variant: tx_ready arrives exactly at wd_cnt == 3.
    step();
    step();
    step();
    tx_ready = 1'b1;
    #1;
    check_eq("wdv_still_busy", 32'(busy), 1);
    step();
    check_eq("wdv_no_err", 32'(timeout_err), 0);
    check_eq("wdv_idle", 32'(busy), 0);
    check_eq("wdv_next_ready", 32'(req_ready), 32'h8);
    step();
    check_eq("wdv_grant3", 32'(grant_id), 3);

    // Mid-transfer reset.
    reset_n = 1'b0;
    #1;
    check_eq("mrst_tx_valid", 32'(tx_valid), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    step();
    reset_n = 1'b1;
    #1;
    check_eq("mrst_ready", 32'(req_ready), 32'h1);
    check_eq("mrst_tx_data", 32'(tx_data), 0);
    check_eq("mrst_grant", 32'(grant_id), 0);
    check_eq("mrst_err", 32'(timeout_err), 0);

    // Packet lock: req 0 sends 01,02,03 (last on 03) while req 1 waits.
`ifdef UART_TX_ARB_LOCK_EN
    exp_g = '{0, 0, 0, 1};
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h22};
`else
    exp_g = '{0, 1, 0, 1};
    exp_d = '{8'h01, 8'h22, 8'h02, 8'h22};
`endif
    n0 = 0;
    req_valid = 4'b0011;
    req_data[7:0] = 8'h01;
    req_last  = 4'b1110;
    tx_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("lock_req_ready", 32'(req_ready), 32'(1) << exp_g[k]);
      step();
      check_eq("lock_grant", 32'(grant_id), 32'(exp_g[k]));
      check_eq("lock_tx_data", 32'(tx_data), 32'(exp_d[k]));
      if (exp_g[k] == 0) begin
        n0++;
        req_data[7:0] = 8'(n0 + 1);
        req_last[0]   = (n0 == 2);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one byte-wide UART transmitter between `NUM_REQ` requesters. Each requester offers bytes on a valid/ready handshake. The arbiter captures one byte, presents it to the transmitter's byte interface, and waits for acceptance. A watchdog drops a byte the transmitter never takes. The block sits between the per-client byte sources and the single UART transmit path.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `TIMEOUT`, 1024 — maximum XFER cycles before a byte is dropped, ≥ 2
- `clk` input 1 — system clock
- `reset_n` input 1 — reset, asynchronous, active-low
- `req_valid` input NUM_REQ — requester i has a byte pending
- `req_data` input NUM_REQ*8 — byte of requester i at bits [8i+7:8i]
- `req_last` input NUM_REQ — byte ends requester i's packet (used only with the lock feature)
- `req_ready` output NUM_REQ — one-hot; byte of requester i is captured this cycle
- `tx_valid` output 1 — byte offered to the transmitter
- `tx_data` output 8 — offered byte
- `tx_ready` input 1 — transmitter accepts `tx_data` this cycle
- `grant_id` output $clog2(NUM_REQ) — index of the current/last granted requester
- `busy` output 1 — high while in XFER
- `timeout_err` output 1 — one-cycle pulse when a byte is dropped

## Operation
- States: IDLE, XFER. Reset state is IDLE.
- IDLE:
  - If any eligible `req_valid`, pick winner w: the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[w]` combinationally in the same cycle.
  - Register `req_data[w]` into `data_reg` and w into `grant_id`, then go to XFER.
  - No eligible request: stay in IDLE, with all `req_ready` = 0.
- XFER:
  - `tx_valid` = 1, `tx_data` = `data_reg`, all `req_ready` = 0.
  - On `tx_ready`: `rr_ptr` ← (w+1) mod NUM_REQ, go to IDLE.
- Watchdog:
  - `wd_cnt` clears on entry to XFER and increments each XFER cycle without `tx_ready`.
  - At `wd_cnt` == TIMEOUT-1 with no `tx_ready`: drop the byte, pulse `timeout_err` next cycle, set `rr_ptr` ← (w+1) mod NUM_REQ, go to IDLE.
  - `tx_ready` in that same cycle wins: the byte counts as accepted and no error is raised.
- `req_valid` dropping while in XFER has no effect, because the byte is already captured.
- `rr_ptr` width is $clog2(NUM_REQ). The wrap is an explicit compare, not natural overflow, so non-power-of-two NUM_REQ works.
- Reset asserted mid-XFER: the byte is lost and no `timeout_err` is raised.

## Timing
- Reset values: `req_ready` = 0, `tx_valid` = 0, `tx_data` = 0, `grant_id` = 0, `busy` = 0, `timeout_err` = 0, `rr_ptr` = 0, `wd_cnt` = 0.
- Capture at cycle t means `tx_valid` is high from t+1. A byte accepted at cycle u frees the arbiter in IDLE at u+1.
- Peak throughput is one byte per 2 cycles.
- `req_ready` is the only combinational output. `tx_valid`, `tx_data`, `busy` and `grant_id` are decoded from registered state and data.
- `tx_data` holds its value between transfers.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- Defined:
  - Capturing a byte with `req_last[w]` = 0 sets `locked` with owner w.
  - While `locked`, only requester w is eligible in IDLE, and other requesters wait regardless of `rr_ptr`.
  - Capturing a byte with `req_last[w]` = 1 clears `locked`.
  - A timeout also clears `locked`.
  - `rr_ptr` advances only when the lock releases.
- Not defined:
  - `req_last` is ignored and every byte is arbitrated independently.
  - No lock register exists.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t` {IDLE, XFER}
  - `BYTE_W` = 8
  - default constants for NUM_REQ and TIMEOUT
- Sub-module `rr_pick`: combinational, with inputs request vector, pointer and eligibility mask, and outputs one-hot grant, index and a found flag.
- The watchdog counter and FSM live in the top module.

## Test plan
- **Reset:** `reset_n` = 0 with all `req_valid` = 1 → every output is 0. Release → `req_ready` = 0001, and `tx_data` = `req_data[0]` one cycle later.
- **Fairness:** all 4 requesters continuously valid, `tx_ready` = 1 → grant order 0,1,2,3,0,…, one byte per 2 cycles, `timeout_err` never asserted.
- **Pointer skip:** only req 2 valid (0x5A), then only req 1 → req 2 captured, `tx_data` = 0x5A. Next grant is req 1 after wrapping from `rr_ptr` = 3.
- **Watchdog:** TIMEOUT = 4, `tx_ready` held 0 → `tx_valid` high for 4 cycles, then `timeout_err` pulses once and the next requester is granted. A variant with `tx_ready` = 1 exactly at `wd_cnt` = 3 → accepted, no error.
- **Lock (with `UART_TX_ARB_LOCK_EN`):** req 0 sends bytes 0x01,0x02,0x03 (last on 0x03) while req 1 is valid → req 1 is granted only after 0x03 is accepted. Without the macro → grants interleave 0,1,0,1.
- **Mid-transfer reset:** `reset_n` asserted in XFER → `tx_valid` drops immediately and the FSM is IDLE after release.
